// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side and transmitter-side signals of the UART TX
// arbiter.
//   master : the arbiter (drives gnt/done/tx_data/tx_data_valid/owner/
//            active/timeout_err; receives req/req_data/tx_busy)
//   slave  : the environment (requesters + UART transmitter)
// Parameters must match those of the uart_tx_arbiter instance it connects to.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int OW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_data_valid;
  logic                          tx_busy;
  logic [OW-1:0]                 owner;
  logic                          active;
  logic                          timeout_err;

  modport master (
    input  req, req_data, tx_busy,
    output gnt, done, tx_data, tx_data_valid, owner, active, timeout_err
  );

  modport slave (
    output req, req_data, tx_busy,
    input  gnt, done, tx_data, tx_data_valid, owner, active, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// sources. A pending requester is picked (search starts after the last
// owner), its byte is launched with a one-cycle tx_data_valid strobe and a
// matching gnt pulse, the transmitter busy flag is tracked through the frame,
// and a done pulse is returned to the owner when busy falls.
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : uart_tx_arbiter_if.master
//          req/req_data (in)     per-requester level request + packed bytes
//          gnt/done (out)        one-hot single-cycle pulses
//          tx_data/tx_data_valid byte and launch strobe to the transmitter
//          tx_busy (in)          transmitter busy flag
//          owner/active (out)    current/last owner, frame in flight
//          timeout_err (out)     busy never rose after launch
//
// Optional feature, macro TX_TIMEOUT_EN:
//   defined   -> WAIT_BUSY gives up after BUSY_TIMEOUT cycles without busy,
//                pulses timeout_err and returns to IDLE without done.
//   undefined -> WAIT_BUSY waits indefinitely; timeout_err stays 0.
// All outputs are registered.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam int          OW        = $clog2(NUM_REQ);
  localparam logic [OW:0] NUM_REQ_W = (OW + 1)'(NUM_REQ);

  if (NUM_REQ < 2 || BUSY_TIMEOUT < 1) begin : g_bad_params
    $error("uart_tx_arbiter: NUM_REQ must be >= 2 and BUSY_TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [OW-1:0]           ptr_q, ptr_d;
  logic [OW-1:0]           owner_q, owner_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    valid_q, valid_d;
  logic                    active_q, active_d;
  logic                    terr_q, terr_d;

`ifdef TX_TIMEOUT_EN
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  logic [CW-1:0] tmo_q, tmo_d;
`endif

  logic [OW-1:0]         pick;
  logic                  found;
  logic [OW:0]           idx;
  logic [DATA_WIDTH-1:0] sel_data;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [OW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  // Rotating priority search: ptr+1 first, wrapping modulo NUM_REQ. idx is one
  // bit wider than an owner index so ptr+k never overflows before the wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (OW + 1)'(k);
      if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
      if (!found && bus.req[idx[OW-1:0]]) begin
        found = 1'b1;
        pick  = idx[OW-1:0];
      end
    end
  end

  assign sel_data = bus.req_data[pick*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    tx_data_d = tx_data_q;
    gnt_d     = '0;
    done_d    = '0;
    valid_d   = 1'b0;
    active_d  = active_q;
    terr_d    = 1'b0;
`ifdef TX_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Never launch onto a transmitter that is still busy (e.g. a frame
        // left running across a reset of this block).
        if (!bus.tx_busy && found) begin
          owner_d   = pick;
          tx_data_d = sel_data;
          gnt_d     = onehot(pick);
          valid_d   = 1'b1;
          active_d  = 1'b1;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
`ifdef TX_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end
`ifdef TX_TIMEOUT_EN
        else if (tmo_q == CW'(BUSY_TIMEOUT - 1)) begin
          terr_d   = 1'b1;
          active_d = 1'b0;
          ptr_d    = owner_q;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done_d   = onehot(owner_q);
          active_d = 1'b0;
          ptr_d    = owner_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage: every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= OW'(NUM_REQ - 1);
      owner_q   <= '0;
      tx_data_q <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      terr_q    <= 1'b0;
`ifdef TX_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      tx_data_q <= tx_data_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      terr_q    <= terr_d;
`ifdef TX_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.done          = done_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = valid_q;
  assign bus.owner         = owner_q;
  assign bus.active        = active_q;
  assign bus.timeout_err   = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter. Stimulus pushes expected launches
// (gnt + byte) and expected done pulses into queues; a monitor pops and
// compares whenever the DUT strobes tx_data_valid or done. A simple
// transmitter model raises tx_busy for frame_len cycles after each launch.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  logic force_busy = 1'b0;
  logic auto_busy  = 1'b0;
  bit   auto_tx    = 1'b0;
  int   frame_len  = 11;

  assign bus.tx_busy = force_busy | auto_busy;

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .BUSY_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [NR-1:0] gnt;
    logic [DW-1:0] data;
  } launch_t;

  launch_t       exp_l[$];
  logic [NR-1:0] exp_d[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_launch = 0;
  int last_launch_cyc = 0;
  int n_tmo = 0;
  int tmo_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_launch(input logic [NR-1:0] g, input logic [DW-1:0] d, input bit with_done);
    launch_t e;
    e.gnt  = g;
    e.data = d;
    exp_l.push_back(e);
    if (with_done) exp_d.push_back(g);
  endtask

  task automatic wait_launches(input int n);
    int b;
    b = 0;
    while (n_launch < n && b < 500) begin
      @(negedge clk);
      #1;
      b++;
    end
    if (n_launch < n) check("wait_launch_bound", 32'(n_launch), 32'(n));
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while ((exp_l.size() != 0 || exp_d.size() != 0 || bus.active !== 1'b0) && b < 500) begin
      @(negedge clk);
      #1;
      b++;
    end
    if (b >= 500) check("wait_drain_bound", 32'(exp_l.size() + exp_d.size()), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter model: busy rises the cycle after the launch strobe and
  // stays up for frame_len cycles.
  initial begin : tx_model
    forever begin
      @(negedge clk);
      if (auto_tx && bus.tx_data_valid === 1'b1) begin
        @(posedge clk);
        #1 auto_busy = 1'b1;
        repeat (frame_len) @(posedge clk);
        #1 auto_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    launch_t       e;
    logic [NR-1:0] d;
    forever begin
      @(negedge clk);
      if (bus.tx_data_valid === 1'b1) begin
        n_launch++;
        last_launch_cyc = cyc;
        if (exp_l.size() == 0) begin
          check("launch_unexpected", 32'(bus.tx_data_valid), 0);
        end else begin
          e = exp_l.pop_front();
          check("launch_gnt", 32'(bus.gnt), 32'(e.gnt));
          check("launch_data", 32'(bus.tx_data), 32'(e.data));
        end
      end else if (bus.gnt !== '0) begin
        check("gnt_without_valid", 32'(bus.gnt), 0);
      end
      if (bus.done !== '0) begin
        if (exp_d.size() == 0) begin
          check("done_unexpected", 32'(bus.done), 0);
        end else begin
          d = exp_d.pop_front();
          check("done_req", 32'(bus.done), 32'(d));
          check("done_latency", 32'(cyc - last_launch_cyc), 32'(frame_len + 2));
        end
      end
      if (bus.timeout_err === 1'b1) begin
        n_tmo++;
        tmo_cyc = cyc;
`ifndef TX_TIMEOUT_EN
        check("timeout_err_unexpected", 32'(bus.timeout_err), 0);
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin : stimulus
    int b;
    int prev;
    int nv;
    int l0;
    bus.req      = '0;
    bus.req_data = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({bus.gnt, bus.done, bus.tx_data, bus.tx_data_valid, bus.owner, bus.active, bus.timeout_err}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single request, exact launch latency and done timing.
    frame_len = 11;
    auto_tx   = 1'b1;
    bus.req_data[7:0] = 8'hA5;
    expect_launch(4'b0001, 8'hA5, 1'b1);
    bus.req = 4'b0001;
    @(negedge clk);
    check("t1_valid", 32'(bus.tx_data_valid), 1);
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    check("t1_active", 32'(bus.active), 1);
    bus.req = '0;
    wait_drain();
    check("t1_owner", 32'(bus.owner), 0);
    check("t1_data_held", 32'(bus.tx_data), 32'hA5);

    // All requesters high from reset: strict rotation 0,1,2,3,0.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    frame_len    = 4;
    bus.req_data = 32'h4332_2110;
    expect_launch(4'b0001, 8'h10, 1'b1);
    expect_launch(4'b0010, 8'h21, 1'b1);
    expect_launch(4'b0100, 8'h32, 1'b1);
    expect_launch(4'b1000, 8'h43, 1'b1);
    expect_launch(4'b0001, 8'h10, 1'b1);
    b    = n_launch;
    prev = 0;
    bus.req = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      wait_launches(b + k);
      if (k > 1) check("t3_launch_gap", 32'(last_launch_cyc - prev), 32'(frame_len + 3));
      prev = last_launch_cyc;
    end
    bus.req = '0;
    wait_drain();

    // Last served = 1, then req=1001: requester 3 before 0.
    bus.req_data[15:8] = 8'h5A;
    expect_launch(4'b0010, 8'h5A, 1'b1);
    b = n_launch;
    bus.req = 4'b0010;
    wait_launches(b + 1);
    bus.req = '0;
    wait_drain();
    bus.req_data[31:24] = 8'hC3;
    bus.req_data[7:0]   = 8'h3C;
    expect_launch(4'b1000, 8'hC3, 1'b1);
    expect_launch(4'b0001, 8'h3C, 1'b1);
    b = n_launch;
    bus.req = 4'b1001;
    wait_launches(b + 1);
    bus.req = 4'b0001;
    wait_launches(b + 2);
    bus.req = '0;
    wait_drain();

    // Busy at reset release: no launch until busy drops.
    @(negedge clk);
    rst        = 1'b1;
    force_busy = 1'b1;
    @(negedge clk) rst = 1'b0;
    bus.req_data[15:8] = 8'h77;
    bus.req = 4'b0010;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.tx_data_valid === 1'b1) nv++;
    end
    check("t5_no_launch_while_busy", 32'(nv), 0);
    expect_launch(4'b0010, 8'h77, 1'b1);
    force_busy = 1'b0;
    @(negedge clk);
    check("t5_launch_after_busy", 32'(bus.tx_data_valid), 1);
    check("t5_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    wait_drain();

    // Reset during WAIT_DONE, then req 0 and 2 pending after reset.
    frame_len = 20;
    bus.req_data[15:8] = 8'h66;
    expect_launch(4'b0010, 8'h66, 1'b0);
    b = n_launch;
    bus.req = 4'b0010;
    wait_launches(b + 1);
    bus.req = '0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_reset_outputs",
          32'({bus.gnt, bus.done, bus.tx_data, bus.tx_data_valid, bus.owner, bus.active, bus.timeout_err}), 0);
    bus.req_data[7:0]   = 8'h0A;
    bus.req_data[23:16] = 8'h2C;
    bus.req = 4'b0101;
    expect_launch(4'b0001, 8'h0A, 1'b1);
    expect_launch(4'b0100, 8'h2C, 1'b1);
    @(negedge clk) rst = 1'b0;
    wait_launches(b + 2);
    check("t6_waited_for_busy", 32'(bus.tx_busy), 0);
    bus.req = 4'b0100;
    wait_launches(b + 3);
    bus.req = '0;
    wait_drain();

    // Busy never rises after launch.
    auto_tx = 1'b0;
    b = n_launch;
`ifdef TX_TIMEOUT_EN
    bus.req_data[7:0]  = 8'hE1;
    bus.req_data[15:8] = 8'hE2;
    expect_launch(4'b0001, 8'hE1, 1'b0);
    expect_launch(4'b0010, 8'hE2, 1'b0);
    bus.req = 4'b0011;
    wait_launches(b + 1);
    l0 = last_launch_cyc;
    bus.req = 4'b0010;
    wait_launches(b + 2);
    bus.req = '0;
    check("t7_timeout_cycle", 32'(tmo_cyc - l0), 17);
    check("t7_next_launch_cycle", 32'(last_launch_cyc - l0), 18);
    repeat (30) @(negedge clk);
    check("t7_timeout_count", 32'(n_tmo), 2);
    check("t7_active_cleared", 32'(bus.active), 0);
`else
    l0 = 0;
    bus.req_data[7:0] = 8'hE1;
    expect_launch(4'b0001, 8'hE1, 1'b0);
    bus.req = 4'b0001;
    wait_launches(b + 1);
    bus.req = '0;
    repeat (40) @(negedge clk);
    check("t7_active_stuck", 32'(bus.active), 1);
    check("t7_owner", 32'(bus.owner), 32'(l0));
    check("t7_no_timeout", 32'(n_tmo), 0);
`endif

    check("launch_queue_empty", 32'(exp_l.size()), 0);
    check("done_queue_empty", 32'(exp_d.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter between NUM_REQ byte sources. It selects one pending requester and presents its byte to the transmitter with a single-cycle data-valid strobe. It then tracks the transmitter's busy flag through the frame and signals completion back to the owning requester. It sits between the per-source request logic and the UART TX top (serializer/parity/mux/FSM).

Parameters:
NUM_REQ, 4, number of requesters (>=2); owner index width OW = $clog2(NUM_REQ)
DATA_WIDTH, 8, byte width passed to the transmitter
BUSY_TIMEOUT, 16, max cycles to wait for tx_busy to rise after launch (used only with TX_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester transmit request, level
req_data  input  NUM_REQ*DATA_WIDTH  packed bytes; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
gnt  output  NUM_REQ  one-hot, 1-cycle pulse: byte of that requester accepted
done  output  NUM_REQ  one-hot, 1-cycle pulse: that requester's frame finished
tx_data  output  DATA_WIDTH  byte to transmitter (P_DATA)
tx_data_valid  output  1  1-cycle launch strobe to transmitter (Data_Valid)
tx_busy  input  1  transmitter busy flag (Busy)
owner  output  OW  index of current or last owner
active  output  1  high from launch until done/abort
timeout_err  output  1  1-cycle pulse on busy timeout (tied 0 without TX_TIMEOUT_EN)

Behaviour:
- All outputs registered. Reset values: gnt=0, done=0, tx_data=0, tx_data_valid=0, owner=0, active=0, timeout_err=0. Internal ptr=NUM_REQ-1 (requester 0 wins first), state=IDLE.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: if tx_busy=0 and req!=0, choose the first set req bit searching ptr+1, ptr+2, ... modulo NUM_REQ. Register owner and tx_data=req_data[owner], then go to LAUNCH. If tx_busy=1, stay in IDLE regardless of req.
- LAUNCH (exactly 1 cycle): tx_data_valid=1, gnt[owner]=1, active=1. Go to WAIT_BUSY. Latency: req sampled at edge T gives tx_data_valid/gnt high in cycle T+1.
- tx_data holds its value from launch until the next launch. It is not cleared at done.
- WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0. Then: done[owner]=1 for 1 cycle, active=0, ptr<=owner, go to IDLE.
- A new arbitration may happen in the same IDLE cycle that follows done. The minimum gap between consecutive tx_data_valid pulses equals frame length + 3 cycles.
- Requesters hold req and req_data stable until gnt. Dropping req before gnt withdraws the request with no side effect. req changes after gnt are ignored for the frame in flight.
- Simultaneous requests: strict rotation. With all req held high, the launch order is 0,1,2,...,NUM_REQ-1,0,...
- A single persistent requester is re-served back-to-back; the pointer wraps onto itself.
- Reset asserted mid-frame: immediate return to reset values. The transmitter's own frame is not aborted by this block. After reset, IDLE waits for tx_busy=0 before launching.
- gnt, done and timeout_err are never asserted in the same cycle for different requesters.

Optional Feature:
- Macro: TX_TIMEOUT_EN.
- With it defined: a counter runs in WAIT_BUSY and clears on entering WAIT_BUSY. If tx_busy has not been seen after BUSY_TIMEOUT cycles, then: timeout_err=1 for 1 cycle, no done pulse, active=0, ptr<=owner, go to IDLE.
- Without it: WAIT_BUSY waits indefinitely, and timeout_err is held 0.

Test Plan:
- Reset then req=0001, req_data[7:0]=0xA5 -> one cycle later tx_data=0xA5, tx_data_valid=1 for 1 cycle, gnt=0001. Model tx_busy high for 11 cycles, then done=0001 1 cycle after tx_busy falls.
- req=1111 held, bytes 0x10/0x21/0x32/0x43 -> four launches with tx_data 0x10,0x21,0x32,0x43 in that order, then 0x10 again; gnt order 0001,0010,0100,1000,0001.
- Last served=1, req=1001 -> requester 3 granted before 0.
- tx_busy=1 at reset release with req=0010 -> no tx_data_valid until tx_busy=0, then launch with gnt=0010.
- Assert rst during WAIT_DONE -> all outputs 0 that cycle. With req=0100 pending and tx_busy=0, the next launch grants requester 0 if req[0]=1, else requester 2.
- TX_TIMEOUT_EN defined, BUSY_TIMEOUT=16, tx_busy stuck 0 after launch -> timeout_err pulse 16 cycles after entering WAIT_BUSY, no done, next requester served. Without the macro, the block stays in WAIT_BUSY and active=1.
